alu_181_serial: RTL

- Multi-cycle, parametrised successor to the 4-bit 74181 ALU slice.
- Executes the full 74181 function set (S[3:0], M, active-low carry) on WIDTH-bit operands by iterating a 4-bit-slice datapath, SLICES slices per cycle, LSB chunk first.
- The inter-chunk carry is held in a register, so a wide ALU costs one slice array instead of a full ripple chain.
- Sits between the register file and the accumulator, with a start/ready/done handshake.

---
 rtl/alu_181_pkg.sv | 23 ++
 rtl/alu_181_slice.sv | 45 ++++
 rtl/alu_181_serial.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_181_pkg.sv
// Shared constants for the serial 74181 ALU: state encoding, common {s, m}
// function codes and the chunk-count helper.
package alu_181_pkg;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    // Function codes packed as {s[3:0], m}; F_ADD/F_DEC/F_A expect cn_b=1, F_SUB expects cn_b=0
    localparam logic [4:0] F_A     = {4'b0000, 1'b0};
    localparam logic [4:0] F_ADD   = {4'b1001, 1'b0};
    localparam logic [4:0] F_SUB   = {4'b0110, 1'b0};
    localparam logic [4:0] F_XOR   = {4'b0110, 1'b1};
    localparam logic [4:0] F_AND   = {4'b1011, 1'b1};
    localparam logic [4:0] F_OR    = {4'b1110, 1'b1};
    localparam logic [4:0] F_NOT_A = {4'b0000, 1'b1};
    localparam logic [4:0] F_DEC   = {4'b1111, 1'b0};

    function automatic int chunk_count(input int width, input int slices);
        return width / (4 * slices);
    endfunction

endpackage

// File: rtl/alu_181_slice.sv
// Combinational 4-bit 74181 slice, active-high data. c3 is the active-high
// carry into bit 3, used for signed-overflow detection by the parent.
module alu_181_slice (
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cn_b,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] f,
    output logic       x,
    output logic       y,
    output logic       cn4_b,
    output logic       aeb,
    output logic       c3
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] half;
    logic [4:0] c;

    // Per-bit propagate/generate and ripple carry; logic mode forces the carry term high
    always_comb begin
        p    = 4'b0000;
        g    = 4'b0000;
        half = 4'b0000;
        f    = 4'b0000;
        c    = 5'b00000;
        c[0] = ~cn_b;
        for (int i = 0; i < 4; i++) begin
            p[i]     = a[i] | (b[i] & s[0]) | (~b[i] & s[1]);
            g[i]     = (a[i] & ~b[i] & s[2]) | (a[i] & b[i] & s[3]);
            half[i]  = p[i] & ~g[i];
            c[i + 1] = g[i] | (p[i] & c[i]);
            f[i]     = half[i] ^ (m | c[i]);
        end
    end

    assign x     = ~(&p);
    assign y     = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]));
    assign cn4_b = ~c[4];
    assign aeb   = &f;
    assign c3    = c[3];

endmodule

// File: rtl/alu_181_serial.sv
// Multi-cycle WIDTH-bit 74181 ALU processing SLICES slices per clock, LSB chunk
// first. Define ALU_181_SERIAL_OVF_EN to add the signed-overflow output ovf.
module alu_181_serial #(
    parameter int WIDTH  = 16,
    parameter int SLICES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn_b,
    output logic [WIDTH-1:0] f,
    output logic             cn4_b,
    output logic             aeb,
    output logic             zero,
    output logic             done
`ifdef ALU_181_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);
    import alu_181_pkg::*;

    localparam int CH = 4 * SLICES;
    localparam int N  = chunk_count(WIDTH, SLICES);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state_r;
    logic [CW-1:0]  cnt_r;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] f_sh;
    logic [3:0]     s_r;
    logic           m_r;
    logic           carry_r;
    logic           aeb_acc_r;

    logic [CH-1:0]      chunk_f;
    logic [SLICES-1:0]  sl_aeb;
    logic [SLICES-1:0]  sl_x;
    logic [SLICES-1:0]  sl_y;
    logic [SLICES-1:0]  sl_c3;
    logic               chunk_co_b;
    logic [WIDTH+CH-1:0] f_cat;
    logic [WIDTH-1:0]   f_next;
    logic               unused_group;

    // Slices chained through per-block carries so the chain is not one flat vector
    for (genvar i = 0; i < SLICES; i++) begin : g_slice
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = carry_r;
        end else begin : g_next
            assign ci = g_slice[i-1].co;
        end
        alu_181_slice u_slice (
            .s     (s_r),
            .m     (m_r),
            .cn_b  (ci),
            .a     (a_sh[4*i +: 4]),
            .b     (b_sh[4*i +: 4]),
            .f     (chunk_f[4*i +: 4]),
            .x     (sl_x[i]),
            .y     (sl_y[i]),
            .cn4_b (co),
            .aeb   (sl_aeb[i]),
            .c3    (sl_c3[i])
        );
    end

    assign chunk_co_b   = g_slice[SLICES-1].co;
    assign f_cat        = {chunk_f, f_sh};
    assign f_next       = f_cat[WIDTH+CH-1:CH];
    assign unused_group = ^{sl_x, sl_y, sl_c3};

    // Handshake FSM, operand shifting, and result/flag registers updated at the last chunk
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            f_sh      <= '0;
            s_r       <= 4'b0000;
            m_r       <= 1'b0;
            carry_r   <= 1'b1;
            aeb_acc_r <= 1'b1;
            ready     <= 1'b1;
            done      <= 1'b0;
            f         <= '0;
            cn4_b     <= 1'b1;
            aeb       <= 1'b0;
            zero      <= 1'b1;
`ifdef ALU_181_SERIAL_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        s_r       <= s;
                        m_r       <= m;
                        carry_r   <= cn_b;
                        aeb_acc_r <= 1'b1;
                        cnt_r     <= '0;
                        ready     <= 1'b0;
                        state_r   <= RUN;
                    end
                end
                RUN: begin
                    a_sh      <= a_sh >> CH;
                    b_sh      <= b_sh >> CH;
                    f_sh      <= f_next;
                    carry_r   <= chunk_co_b;
                    aeb_acc_r <= aeb_acc_r & (&sl_aeb);
                    if (cnt_r == LAST) begin
                        f       <= f_next;
                        cn4_b   <= m_r | chunk_co_b;
                        aeb     <= aeb_acc_r & (&sl_aeb);
                        zero    <= (f_next == '0);
`ifdef ALU_181_SERIAL_OVF_EN
                        ovf     <= ~m_r & (sl_c3[SLICES-1] ^ ~chunk_co_b);
`endif
                        done    <= 1'b1;
                        ready   <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule
